// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_pkg
// Brief    : Shared constants and FSM state type for the MAC frame checker.
// Revision : 1.0
// ============================================================================
package mac_pkg;
    localparam logic [63:0] PREAMBLE_SFD     = 64'hD555555555555555;
    localparam logic [15:0] MIN_PAYLOAD_SIZE = 16'd46;
    localparam logic [15:0] HEADER_BYTES     = 16'd14;
    localparam logic [15:0] FCS_BYTES        = 16'd4;
    localparam logic [31:0] CRC_POLY         = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT         = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR0    = 3'd1,
        HDR1    = 3'd2,
        PAYLOAD = 3'd3,
        DONE    = 3'd4
    } state_t;
endpackage
`default_nettype wire

// File: rtl/crc32_d64.sv
`default_nettype none
// ============================================================================
// Module   : crc32_d64
// Brief    : Combinational reflected CRC-32 update over up to 8 enabled bytes.
// Revision : 1.0
// ============================================================================
module crc32_d64
    import mac_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [63:0] i_data,
    input  logic [7:0]  i_byte_en,
    output logic [31:0] o_crc
);
    logic [31:0] w_c;

    always_comb begin
        w_c = i_crc;
        for (int k = 0; k < 8; k++) begin
            if (i_byte_en[k]) begin
                for (int b = 0; b < 8; b++) begin
                    w_c = (w_c >> 1) ^ (CRC_POLY & {32{w_c[0] ^ i_data[8*k+b]}});
                end
            end
        end
    end

    assign o_crc = w_c;
endmodule
`default_nettype wire

// File: rtl/mac_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : mac_frame_checker
// Brief    : Parses 64-bit Ethernet frame words, extracts header/payload, checks FCS.
// Revision : 1.0
// ============================================================================
module mac_frame_checker
    import mac_pkg::*;
#(
    parameter int PAYLOAD_MAX_SIZE = 1500
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [63:0] i_data,
    output logic [47:0] o_dest_address,
    output logic [47:0] o_src_address,
    output logic [15:0] o_payload_length,
    output logic        o_payload_valid,
    output logic [63:0] o_payload_data,
    output logic [7:0]  o_payload_keep,
    output logic        o_frame_done,
    output logic        o_crc_ok,
    output logic        o_len_err,
    output logic        o_busy
);
    localparam logic [16:0] c_MAX = 17'(PAYLOAD_MAX_SIZE);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [31:0] r_crc;
    logic [31:0] r_fcs;

    logic [15:0] w_len;
    logic [15:0] w_len_eff;
    logic [15:0] w_total;
    logic [15:0] w_crc_end;
    logic [7:0]  w_crc_en;
    logic [7:0]  w_keep;
    logic [7:0]  w_fcs_hit;
    logic [1:0]  w_pos [8];
    logic [31:0] w_crc_next;
    logic [31:0] w_fcs_next;
    logic        w_last;
    logic        w_len_bad;

    // The length field arrives in the HDR1 word; afterwards use the captured copy.
    assign w_len     = (r_state == HDR1) ? i_data[47:32] : o_payload_length;
    assign w_len_eff = (w_len < MIN_PAYLOAD_SIZE) ? MIN_PAYLOAD_SIZE : w_len;
    assign w_total   = HEADER_BYTES + w_len_eff + FCS_BYTES;
    assign w_crc_end = w_total - FCS_BYTES;
    assign w_last    = (r_cnt + 16'd8) >= w_total;
    assign w_len_bad = (r_state == HDR1) && ({1'b0, w_len} > c_MAX);

    for (genvar k = 0; k < 8; k++) begin : g_byte
        logic [15:0] w_idx;
        assign w_idx        = r_cnt + 16'(k);
        assign w_crc_en[k]  = w_idx < w_crc_end;
        assign w_keep[k]    = (w_idx >= HEADER_BYTES) && (w_idx < HEADER_BYTES + w_len);
        assign w_fcs_hit[k] = (w_idx >= w_crc_end) && (w_idx < w_total);
        assign w_pos[k]     = w_idx[1:0] - w_crc_end[1:0];
    end

    // FCS may straddle two words, so bytes are merged into a running register.
    always_comb begin
        w_fcs_next = r_fcs;
        for (int k = 0; k < 8; k++) begin
            if (w_fcs_hit[k]) begin
                w_fcs_next[{w_pos[k], 3'b000} +: 8] = i_data[8*k +: 8];
            end
        end
    end

    crc32_d64 u_crc (
        .i_crc     (r_crc),
        .i_data    (i_data),
        .i_byte_en (w_crc_en),
        .o_crc     (w_crc_next)
    );

    assign o_busy = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state          <= IDLE;
            r_cnt            <= 16'd0;
            r_crc            <= CRC_INIT;
            r_fcs            <= 32'd0;
            o_dest_address   <= 48'd0;
            o_src_address    <= 48'd0;
            o_payload_length <= 16'd0;
            o_payload_valid  <= 1'b0;
            o_payload_data   <= 64'd0;
            o_payload_keep   <= 8'd0;
            o_frame_done     <= 1'b0;
            o_crc_ok         <= 1'b0;
            o_len_err        <= 1'b0;
        end else begin
            o_frame_done    <= 1'b0;
            o_payload_valid <= 1'b0;
            o_payload_keep  <= 8'd0;
            case (r_state)
                IDLE: begin
                    if (i_valid && (i_data == PREAMBLE_SFD)) begin
                        r_state <= HDR0;
                        r_cnt   <= 16'd0;
                        r_crc   <= CRC_INIT;
                        r_fcs   <= 32'd0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    if (i_valid) begin
                        r_cnt <= r_cnt + 16'd8;
                        r_crc <= w_crc_next;
                        r_fcs <= w_fcs_next;
                        if (r_state == HDR0) begin
                            o_dest_address       <= i_data[47:0];
                            o_src_address[15:0]  <= i_data[63:48];
                            r_state              <= HDR1;
                        end else begin
                            if (r_state == HDR1) begin
                                o_src_address[47:16] <= i_data[31:0];
                                o_payload_length     <= i_data[47:32];
                            end
                            if (w_len_bad) begin
                                r_state      <= DONE;
                                o_frame_done <= 1'b1;
                                o_len_err    <= 1'b1;
                                o_crc_ok     <= 1'b0;
                            end else begin
                                if (|w_keep) begin
                                    o_payload_valid <= 1'b1;
                                    o_payload_data  <= i_data;
                                    o_payload_keep  <= w_keep;
                                end
                                if (w_last) begin
                                    r_state      <= DONE;
                                    o_frame_done <= 1'b1;
                                    o_len_err    <= 1'b0;
                                    o_crc_ok     <= (~w_crc_next == w_fcs_next);
                                end else begin
                                    r_state <= PAYLOAD;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/mac_frame_checker.md
MAC_FRAME_CHECKER -- requirements
Module: mac_frame_checker

Interface
REQ-001 The block SHALL have parameter PAYLOAD_MAX_SIZE, default 1500: largest accepted payload length in bytes.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port i_valid, input, 1 bit: i_data holds a frame word this cycle.
REQ-006 The block SHALL have port i_data, input, 64 bits: frame word; byte k is in bits [8k+7:8k], and byte 0 is first on the wire.
REQ-007 The block SHALL have port o_dest_address, output, 48 bits: captured destination address, wire byte 0 in bits [7:0].
REQ-008 The block SHALL have port o_src_address, output, 48 bits: captured source address, same byte order.
REQ-009 The block SHALL have port o_payload_length, output, 16 bits: captured length field, first wire byte in bits [7:0].
REQ-010 The block SHALL have port o_payload_valid, output, 1 bit: o_payload_data/o_payload_keep are valid.
REQ-011 The block SHALL have port o_payload_data, output, 64 bits: registered copy of the accepted word.
REQ-012 The block SHALL have port o_payload_keep, output, 8 bits: bit k set iff byte k is a payload byte (excludes header, padding, FCS).
REQ-013 The block SHALL have port o_frame_done, output, 1 bit: one-cycle pulse at end of frame, normal or error.
REQ-014 The block SHALL have port o_crc_ok, output, 1 bit: FCS matched; valid while o_frame_done=1.
REQ-015 The block SHALL have port o_len_err, output, 1 bit: length field > PAYLOAD_MAX_SIZE; valid while o_frame_done=1.
REQ-016 The block SHALL have port o_busy, output, 1 bit: FSM not in IDLE.

Function
REQ-017 FSM states SHALL be IDLE, HDR0, HDR1, PAYLOAD, DONE.
REQ-018 In IDLE, an accepted word equal to 64'hD555555555555555 SHALL move the FSM to HDR0; any other word SHALL be discarded.
REQ-019 Cycles with i_valid=0 SHALL hold state, counters and CRC, with no timeout.
REQ-020 HDR0 SHALL capture dest bytes 0-5 and src bytes 0-1, then go to HDR1.
REQ-021 HDR1 SHALL capture src bytes 2-5 and length L from bytes 4-5; bytes 6-7 SHALL be the first payload/pad bytes.
REQ-022 Total post-SFD byte count SHALL be N = 14 + max(L,46) + 4, computed in 16 bits.
REQ-023 A 16-bit counter SHALL track post-SFD bytes accepted.
REQ-024 Bytes beyond N in the final word SHALL be ignored by both CRC and keep.
REQ-025 o_payload_keep SHALL mark only post-SFD byte indices 14 .. 14+L-1.
REQ-026 A word with no payload bytes SHALL leave o_payload_valid=0.
REQ-027 CRC SHALL be IEEE 802.3 CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF, final inversion) over bytes 0 .. N-5.
REQ-028 The received FCS (bytes N-4 .. N-1) SHALL be taken least-significant byte first.
REQ-029 o_crc_ok SHALL be 1 iff the computed CRC equals the received FCS.
REQ-030 The FSM SHALL enter DONE after accepting the word that contains byte N-1.
REQ-031 In DONE, o_frame_done SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
REQ-032 A word accepted while in DONE SHALL be discarded.
REQ-033 If L > PAYLOAD_MAX_SIZE in HDR1, the FSM SHALL go to DONE with o_len_err=1, o_crc_ok=0, and no payload output.
REQ-034 Latency from accepted word to o_payload_* SHALL be 1 cycle.
REQ-035 Latency from the last frame word to o_frame_done SHALL be 1 cycle.
REQ-036 Captured header outputs SHALL hold until the next HDR0/HDR1 capture.
REQ-037 A preamble/SFD pattern inside a frame SHALL be treated as data.

Reset
REQ-038 While i_rst=1, the FSM SHALL be IDLE and the counter 0.
REQ-039 While i_rst=1, the CRC SHALL be 0xFFFFFFFF and every output SHALL be 0.
REQ-040 A reset mid-frame SHALL abandon the frame with no o_frame_done pulse.

Structure
REQ-041 Package mac_pkg SHALL hold PREAMBLE_SFD, MIN_PAYLOAD_SIZE=46, HEADER_BYTES=14, FCS_BYTES=4, the CRC polynomial/init and the FSM state enum.
REQ-042 Sub-module crc32_d64 SHALL compute the combinational CRC update over a 64-bit word with an 8-bit byte-enable mask.

Verification
REQ-043 L=8 frame, payload 01..08, correct FCS -> keep=8'hC0 on the HDR1 word, one-cycle done, crc_ok=1, length=8, dest/src match.
REQ-044 Same frame with one FCS bit flipped -> done=1, crc_ok=0, len_err=0.
REQ-045 L=1501 -> done 1 cycle after the HDR1 word, len_err=1, no payload_valid after HDR1.
REQ-046 L=100 frame with i_valid toggled 1/0 every cycle -> outputs identical to gapless run, except timing.
REQ-047 i_rst pulsed during PAYLOAD, then a new L=46 frame -> no done for the first frame; second frame crc_ok=1.
REQ-048 Idle garbage 64'h0 and 64'h5555555555555555 before a frame -> ignored; frame decoded normally.
